// File: rtl/adc_fifo_read_arbiter.sv
// adc_fifo_read_arbiter
//   Owns the single read port of the ADC sample FIFO (clk_usb domain) and
//   shares it between single-word register reads and multi-word stream
//   bursts. Stream reads are paced into segments of segment_threshold words,
//   reads wanted while the FIFO is empty are counted, and each issued read is
//   tagged so the downstream mux can route the returning data.
//
// Ports
//   clk_usb, reset_n        clock, asynchronous active-low reset
//   enable                  low blocks new grants and aborts a running burst
//   reg_rd_req              1-cycle pulse, register path wants one word
//   reg_rd_pending          register request held, not yet issued
//   reg_rd_overrun          sticky, request arrived while one was pending
//   strm_req                level, stream engine wants a burst
//   strm_burst_len          words per burst, sampled at grant (0 = no-op)
//   strm_grant              high for the whole burst
//   fifo_empty, fifo_rd_en  FIFO status / read strobe
//   rd_tag                  00 none, 01 register, 10 stream; aligned to data
//   segment_threshold       stream words per segment (0 = no segmentation)
//   segment_done            stream paused at a segment boundary
//   segment_ack             1-cycle pulse releasing the pause
//   underflow_count         saturating count of reads wanted while empty
//   clear_counts            sync clear of underflow, overrun, segment counter

module adc_fifo_read_arbiter #(
  parameter int pRD_LAT = 1,
  parameter int pLEN_W  = 8
) (
  input  logic              clk_usb,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              reg_rd_req,
  output logic              reg_rd_pending,
  output logic              reg_rd_overrun,
  input  logic              strm_req,
  input  logic [pLEN_W-1:0] strm_burst_len,
  output logic              strm_grant,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [1:0]        rd_tag,
  input  logic [16:0]       segment_threshold,
  output logic              segment_done,
  input  logic              segment_ack,
  output logic [7:0]        underflow_count,
  input  logic              clear_counts
);

  localparam int unsigned LAT = pRD_LAT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REG,
    ST_BURST,
    ST_SEG_PAUSE
  } state_t;

  state_t            state_q, state_d;
  logic [pLEN_W-1:0] rem_q, rem_d;
  logic [16:0]       seg_cnt_q, seg_cnt_d, seg_cnt_inc;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              grant_q, done_q;
  logic [7:0]        uflow_q, uflow_d;
  logic [1:0]        tag_pipe_q [LAT];
  logic [1:0]        tag_pipe_d [LAT];

  logic              rd_en;
  logic              uflow_inc;
  logic              reg_serve;
  logic              seg_hit;
  logic [1:0]        issue_tag;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    seg_cnt_d   = seg_cnt_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    uflow_d     = uflow_q;
    rd_en       = 1'b0;
    uflow_inc   = 1'b0;
    issue_tag   = 2'b00;
    seg_cnt_inc = seg_cnt_q + 17'd1;
    // Live threshold compare with >= so a lowered threshold pauses on the next read.
    seg_hit     = (segment_threshold != '0) && (seg_cnt_inc >= segment_threshold);
    // A pending register read is serviced from REG, or directly while paused.
    reg_serve   = (state_q == ST_REG) ||
                  ((state_q == ST_SEG_PAUSE) && pend_q && enable);

    case (state_q)
      ST_IDLE: begin
        if (pend_q && enable) begin
          state_d = ST_REG;
        end else if (strm_req && enable && (strm_burst_len != '0)) begin
          rem_d   = strm_burst_len;
          state_d = ST_BURST;
        end
      end
      ST_REG: begin
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          rd_en     = 1'b1;
          issue_tag = 2'b10;
          rem_d     = rem_q - pLEN_W'(1);
          seg_cnt_d = seg_cnt_inc;
          if (seg_hit) begin
            rem_d   = '0;
            state_d = ST_SEG_PAUSE;
          end else if (rem_q == pLEN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end else begin
          uflow_inc = 1'b1;
        end
      end
      ST_SEG_PAUSE: begin
        if (segment_ack) begin
          seg_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reg_serve) begin
      pend_d = 1'b0;
      if (!fifo_empty) begin
        rd_en     = 1'b1;
        issue_tag = 2'b01;
      end else begin
        uflow_inc = 1'b1;
      end
    end

    if (reg_rd_req) begin
      if (pend_q) begin
        ovr_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end

    if (uflow_inc && (uflow_q != 8'hFF)) begin
      uflow_d = uflow_q + 8'd1;
    end

    if (clear_counts) begin
      uflow_d   = '0;
      ovr_d     = 1'b0;
      seg_cnt_d = '0;
    end
  end

  always_comb begin
    tag_pipe_d[0] = issue_tag;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      seg_cnt_q  <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      grant_q    <= 1'b0;
      done_q     <= 1'b0;
      uflow_q    <= '0;
      tag_pipe_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      seg_cnt_q  <= seg_cnt_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      grant_q    <= (state_d == ST_BURST);
      done_q     <= (state_d == ST_SEG_PAUSE);
      uflow_q    <= uflow_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign fifo_rd_en      = rd_en;
  assign rd_tag          = tag_pipe_q[LAT-1];
  assign reg_rd_pending  = pend_q;
  assign reg_rd_overrun  = ovr_q;
  assign strm_grant      = grant_q;
  assign segment_done    = done_q;
  assign underflow_count = uflow_q;

endmodule
